decode_imm_stage: RTL

Registered immediate-decode stage for the RV32/RV64 decode pipeline. It accepts one instruction word plus PC per handshake, classifies the immediate format from the opcode, and extracts the sign- or zero-extended immediate to XLEN. It flags unsupported opcodes and presents the result one cycle later on a valid/ready output interface. An optional skid buffer makes in_ready a pure register output. It sits between fetch and the register-read/execute stages.

---
 rtl/decode_imm_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/decode_imm_stage.sv
// rtl/decode_imm_stage.sv - registered RV32/RV64 immediate decode stage with optional skid buffer
module decode_imm_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_C    = 3'd6;

    logic [2:0]      dec_type;
    logic            dec_ill;
    logic [XLEN-1:0] dec_imm;

    logic            out_valid_q, out_valid_d;
    logic            skid_full_q, skid_full_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] out_imm_q, out_pc_q, skid_imm_q, skid_pc_q;
    logic [2:0]      out_type_q, skid_type_q;
    logic            out_ill_q, skid_ill_q;
    logic            in_fire, load_out, from_skid, load_skid;

    always_comb begin
        dec_type = T_NONE;
        dec_ill  = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (in_instr[6:2])
                5'b11001, 5'b00000, 5'b00100: dec_type = T_I;
                5'b00110: if (XLEN == 64) dec_type = T_I; else dec_ill = 1'b1;
                5'b01000: dec_type = T_S;
                5'b11000: dec_type = T_B;
                5'b01101, 5'b00101: dec_type = T_U;
                5'b11011: dec_type = T_J;
                5'b11100: dec_type = T_C;
                5'b01100, 5'b00011: dec_type = T_NONE;
                5'b01110: if (XLEN != 64) dec_ill = 1'b1;
                default: dec_ill = 1'b1;
            endcase
        end
    end

    always_comb begin
        dec_imm = '0;
        case (dec_type)
            T_I: dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            T_S: dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            T_B: dec_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            T_U: dec_imm = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
            T_J: dec_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            T_C: dec_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
            default: dec_imm = '0;
        endcase
    end

    // Without a skid buffer in_ready_q only masks the reset period.
    assign in_ready = (SKID != 0) ? in_ready_q : (in_ready_q & (~out_valid_q | out_ready));
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        load_out    = 1'b0;
        from_skid   = 1'b0;
        load_skid   = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (out_valid_q && !out_ready) begin
            if (in_fire) begin
                load_skid   = 1'b1;
                skid_full_d = 1'b1;
            end
        end else if (skid_full_q) begin
            load_out    = 1'b1;
            from_skid   = 1'b1;
            skid_full_d = 1'b0;
            out_valid_d = 1'b1;
        end else begin
            load_out    = in_fire;
            out_valid_d = in_fire;
        end
        in_ready_d = (SKID != 0) ? ~skid_full_d : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
            out_type_q  <= T_NONE;
            out_ill_q   <= 1'b0;
            skid_imm_q  <= '0;
            skid_pc_q   <= '0;
            skid_type_q <= T_NONE;
            skid_ill_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            in_ready_q  <= in_ready_d;
            if (load_out) begin
                out_imm_q  <= from_skid ? skid_imm_q  : dec_imm;
                out_pc_q   <= from_skid ? skid_pc_q   : in_pc;
                out_type_q <= from_skid ? skid_type_q : dec_type;
                out_ill_q  <= from_skid ? skid_ill_q  : dec_ill;
            end
            if (load_skid) begin
                skid_imm_q  <= dec_imm;
                skid_pc_q   <= in_pc;
                skid_type_q <= dec_type;
                skid_ill_q  <= dec_ill;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm      = out_imm_q;
    assign out_imm_type = out_type_q;
    assign out_pc       = out_pc_q;
    assign out_illegal  = out_ill_q;

endmodule
